// File: rtl/lvds_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : lvds_rx_pkg                                                |
// | Brief   : Shared constants and state type for the LVDS receive path. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package lvds_rx_pkg;

    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;
    localparam logic [3:0] SLIP_MAX  = 4'd9;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SETTLE = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } align_state_t;

endpackage
`default_nettype wire

// File: rtl/comma_detect_10b.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : comma_detect_10b                                            |
// | Brief  : Combinational K28.5 match, either running disparity.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module comma_detect_10b
    import lvds_rx_pkg::*;
(
    input  logic [9:0] i_data,
    output logic       o_comma
);

    assign o_comma = (i_data == K28_5_RDN) || (i_data == K28_5_RDP);

endmodule
`default_nettype wire

// File: rtl/word_aligner_10b.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : word_aligner_10b                                            |
// | Brief  : Steps gearbox slip until K28.5 commas land word-aligned.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module word_aligner_10b
    import lvds_rx_pkg::*;
#(
    parameter int SEARCH_WINDOW = 64,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_COUNT    = 4,
    parameter int LOSS_WINDOW   = 256
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [9:0] datain,
    input  logic       enable,
    input  logic       realign,
    output logic [3:0] slip_bits,
    output logic [9:0] dataout,
    output logic       comma,
    output logic       aligned,
    output logic [7:0] slip_count
);

    localparam int c_WIN_SPAN = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
    localparam int c_WIN_W    = $clog2(c_WIN_SPAN) + 1;
    localparam int c_SET_W    = $clog2(SETTLE_CYCLES) + 1;
    localparam int c_HIT_W    = $clog2(LOCK_COUNT) + 1;

    localparam logic [c_WIN_W-1:0] c_SEARCH_LAST = c_WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [c_WIN_W-1:0] c_LOSS_LAST   = c_WIN_W'(LOSS_WINDOW - 1);
    localparam logic [c_WIN_W-1:0] c_WIN_SAT     = '1;
    localparam logic [c_SET_W-1:0] c_SETTLE_LAST = c_SET_W'(SETTLE_CYCLES - 1);
    localparam logic [c_HIT_W-1:0] c_LOCK_LAST   = c_HIT_W'(LOCK_COUNT - 1);

    align_state_t       r_state;
    align_state_t       w_state_nxt;
    logic [c_WIN_W-1:0] r_win;
    logic [c_WIN_W-1:0] w_win_nxt;
    logic [c_SET_W-1:0] r_set;
    logic [c_SET_W-1:0] w_set_nxt;
    logic [c_HIT_W-1:0] r_hits;
    logic [c_HIT_W-1:0] w_hits_nxt;
    logic               w_slip_adv;
    logic [3:0]         w_slip_next;
    logic [3:0]         r_slip;
    logic [7:0]         r_slip_cnt;
    logic               r_aligned;
    logic [9:0]         r_dataout;
    logic               r_comma;
    logic               w_comma;

    comma_detect_10b u_comma_detect (
        .i_data  (datain),
        .o_comma (w_comma)
    );

    assign w_slip_next = (r_slip == SLIP_MAX) ? 4'd0 : r_slip + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = (r_win == c_WIN_SAT) ? r_win : r_win + 1'b1;
        w_set_nxt   = '0;
        w_hits_nxt  = r_hits;
        w_slip_adv  = 1'b0;
        // enable outranks realign; both force a clean re-hunt at the current slip
        if (!enable || realign) begin
            w_state_nxt = HUNT;
            w_win_nxt   = '0;
            w_hits_nxt  = '0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (w_comma) begin
                        w_state_nxt = VERIFY;
                        w_win_nxt   = '0;
                        w_hits_nxt  = c_HIT_W'(1);
                    end else if (r_win == c_SEARCH_LAST) begin
                        w_state_nxt = SETTLE;
                        w_win_nxt   = '0;
                        w_slip_adv  = 1'b1;
                    end
                end
                SETTLE: begin
                    w_win_nxt = '0;
                    if (r_set == c_SETTLE_LAST) begin
                        w_state_nxt = HUNT;
                    end else begin
                        w_set_nxt = r_set + 1'b1;
                    end
                end
                VERIFY: begin
                    if (w_comma) begin
                        w_win_nxt = '0;
                        if (r_hits == c_LOCK_LAST) begin
                            w_state_nxt = LOCKED;
                            w_hits_nxt  = '0;
                        end else begin
                            w_hits_nxt = r_hits + 1'b1;
                        end
                    end else if (r_win == c_SEARCH_LAST) begin
                        w_state_nxt = SETTLE;
                        w_win_nxt   = '0;
                        w_hits_nxt  = '0;
                        w_slip_adv  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_comma) begin
                        w_win_nxt = '0;
                    end else if (r_win == c_LOSS_LAST) begin
                        w_state_nxt = HUNT;
                        w_win_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_win_nxt   = '0;
                    w_hits_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= HUNT;
            r_win      <= '0;
            r_set      <= '0;
            r_hits     <= '0;
            r_slip     <= '0;
            r_slip_cnt <= '0;
            r_aligned  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_win     <= w_win_nxt;
            r_set     <= w_set_nxt;
            r_hits    <= w_hits_nxt;
            r_aligned <= (w_state_nxt == LOCKED);
            if (w_slip_adv) begin
                r_slip <= w_slip_next;
                if (r_slip_cnt != 8'hFF) begin
                    r_slip_cnt <= r_slip_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dataout <= '0;
            r_comma   <= 1'b0;
        end else begin
            r_dataout <= datain;
            r_comma   <= w_comma;
        end
    end

    assign slip_bits  = r_slip;
    assign slip_count = r_slip_cnt;
    assign aligned    = r_aligned;
    assign dataout    = r_dataout;
    assign comma      = r_comma;

endmodule
`default_nettype wire

// File: tb/tb_word_aligner_10b.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_word_aligner_10b                                         |
// | Brief  : Serial source + gearbox model driving the aligner, checked  |
// |          every cycle against a timestamp-based behavioural model.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_word_aligner_10b;
    import lvds_rx_pkg::*;

    localparam int SEARCH_WINDOW = 64;
    localparam int SETTLE_CYCLES = 8;
    localparam int LOCK_COUNT    = 4;
    localparam int LOSS_WINDOW   = 256;
    localparam int STREAM_LEN    = 2048;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b0;
    logic       realign = 1'b0;
    logic [9:0] datain  = '0;
    logic [3:0] slip_bits;
    logic [9:0] dataout;
    logic       comma;
    logic       aligned;
    logic [7:0] slip_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    word_aligner_10b #(
        .SEARCH_WINDOW (SEARCH_WINDOW),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .LOCK_COUNT    (LOCK_COUNT),
        .LOSS_WINDOW   (LOSS_WINDOW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .datain     (datain),
        .enable     (enable),
        .realign    (realign),
        .slip_bits  (slip_bits),
        .dataout    (dataout),
        .comma      (comma),
        .aligned    (aligned),
        .slip_count (slip_count)
    );

    // serial source: word-aligned stream, with a gearbox offset applied on read
    logic [9:0] strm    [0:STREAM_LEN-1];
    bit         planned [0:STREAM_LEN-1];
    int         sidx;
    int         target;
    int         quiet_run;

    // reference model: times measured as absolute edge numbers
    string      m_phase;
    int         m_cyc = 0;
    int         m_mark;
    int         m_settle_end;
    int         m_hits;
    int         m_slip;
    int         m_slips;
    logic [9:0] m_data;
    bit         m_comma;

    function automatic bit is_k(input logic [9:0] w);
        return (w == K28_5_RDN) || (w == K28_5_RDP);
    endfunction

    function automatic logic [9:0] window(input logic [9:0] cur, input logic [9:0] nxt, input int d);
        logic [19:0] pair;
        pair = {nxt, cur} >> d;
        return pair[9:0];
    endfunction

    function automatic bit shifted_clean(input logic [9:0] cur, input logic [9:0] nxt);
        for (int d = 1; d < 10; d++) begin
            if (is_k(window(cur, nxt, d))) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic build_stream(input bit with_commas);
        int pos;
        for (int i = 0; i < STREAM_LEN; i++) planned[i] = 1'b0;
        if (with_commas) begin
            pos = $urandom_range(4, 1);
            while (pos < STREAM_LEN) begin
                planned[pos] = 1'b1;
                strm[pos]    = ($urandom_range(1, 0) == 1) ? K28_5_RDP : K28_5_RDN;
                pos += $urandom_range(12, 6);
            end
        end
        for (int i = 0; i < STREAM_LEN; i++) begin
            if (!planned[i]) begin
                logic [9:0] w;
                bit         ok;
                int         tries;
                tries = 0;
                ok    = 1'b0;
                while (!ok && tries < 1000) begin
                    w  = 10'($urandom);
                    ok = !is_k(w);
                    if (ok && i > 0) ok = shifted_clean(strm[i-1], w);
                    if (ok && i < STREAM_LEN - 1) begin
                        if (planned[i+1]) ok = shifted_clean(w, strm[i+1]);
                    end
                    tries++;
                end
                strm[i] = w;
            end
        end
        sidx = 0;
    endtask

    task automatic model_reset();
        m_phase = "hunt";
        m_mark  = m_cyc;
        m_hits  = 0;
        m_slip  = 0;
        m_slips = 0;
        m_data  = '0;
        m_comma = 1'b0;
    endtask

    task automatic model_step(input logic [9:0] w, input bit en, input bit ra);
        int c;
        bit hit;
        c       = m_cyc;
        hit     = is_k(w);
        m_data  = w;
        m_comma = hit;
        if (!en || ra) begin
            m_phase = "hunt";
            m_mark  = c + 1;
            m_hits  = 0;
        end else if (m_phase == "hunt" || m_phase == "verify") begin
            if (hit) begin
                m_hits  = (m_phase == "hunt") ? 1 : m_hits + 1;
                m_mark  = c + 1;
                m_phase = (m_hits == LOCK_COUNT) ? "locked" : "verify";
            end else if (c - m_mark == SEARCH_WINDOW - 1) begin
                m_slip       = (m_slip + 1) % 10;
                m_slips      = (m_slips < 255) ? m_slips + 1 : 255;
                m_hits       = 0;
                m_settle_end = c + SETTLE_CYCLES;
                m_phase      = "settle";
            end
        end else if (m_phase == "settle") begin
            if (c == m_settle_end) begin
                m_phase = "hunt";
                m_mark  = c + 1;
            end
        end else begin
            if (hit) begin
                m_mark = c + 1;
            end else if (c - m_mark == LOSS_WINDOW - 1) begin
                m_phase = "hunt";
                m_mark  = c + 1;
            end
        end
        m_cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inputs change on the falling edge; outputs are sampled 1 ns after the rising edge
    task automatic cycle(input logic [9:0] w, input bit en, input bit ra);
        datain  = w;
        enable  = en;
        realign = ra;
        quiet_run = is_k(w) ? 0 : quiet_run + 1;
        @(posedge clock);
        #1;
        model_step(w, en, ra);
        chk("dataout",    32'(dataout),    32'(m_data));
        chk("comma",      32'(comma),      32'(m_comma));
        chk("aligned",    32'(aligned),    32'(m_phase == "locked"));
        chk("slip_bits",  32'(slip_bits),  32'(m_slip));
        chk("slip_count", 32'(slip_count), 32'(m_slips));
        @(negedge clock);
    endtask

    task automatic gb_cycle(input bit en, input bit ra);
        int         d;
        logic [9:0] w;
        d = (int'(slip_bits) - target + 10) % 10;
        w = window(strm[sidx], strm[sidx+1], d);
        if (sidx < STREAM_LEN - 2) sidx++;
        cycle(w, en, ra);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wrap_seen;
        int prev_slip;
        quiet_run = 0;

        // reset values before any active edge
        repeat (3) @(posedge clock);
        #1;
        chk("reset_slip_bits",  32'(slip_bits),  32'd0);
        chk("reset_aligned",    32'(aligned),    32'd0);
        chk("reset_comma",      32'(comma),      32'd0);
        chk("reset_dataout",    32'(dataout),    32'd0);
        chk("reset_slip_count", 32'(slip_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();

        // no commas at all: three full search+settle periods
        build_stream(1'b0);
        target = 0;
        repeat (3 * (SEARCH_WINDOW + SETTLE_CYCLES)) gb_cycle(1'b1, 1'b0);
        chk("search_slip_bits",  32'(slip_bits),  32'd3);
        chk("search_slip_count", 32'(slip_count), 32'd3);

        // commas visible only at slip 3
        build_stream(1'b1);
        target = 3;
        for (int k = 0; k < 400 && aligned !== 1'b1; k++) gb_cycle(1'b1, 1'b0);
        chk("lock3_aligned",   32'(aligned),   32'd1);
        chk("lock3_slip_bits", 32'(slip_bits), 32'd3);
        chk("lock3_comma",     32'(comma),     32'd1);

        // loss of lock after LOSS_WINDOW comma-free cycles
        repeat ($urandom_range(10, 3)) gb_cycle(1'b1, 1'b0);
        build_stream(1'b0);
        for (int k = 0; k < 400 && quiet_run < LOSS_WINDOW - 1; k++) gb_cycle(1'b1, 1'b0);
        chk("loss_held_aligned", 32'(aligned), 32'd1);
        gb_cycle(1'b1, 1'b0);
        chk("loss_aligned",   32'(aligned),   32'd0);
        chk("loss_slip_bits", 32'(slip_bits), 32'd3);

        // relock, then realign coinciding with a comma
        build_stream(1'b1);
        for (int k = 0; k < 400 && aligned !== 1'b1; k++) gb_cycle(1'b1, 1'b0);
        chk("relock_aligned", 32'(aligned), 32'd1);
        cycle(K28_5_RDP, 1'b1, 1'b1);
        chk("realign_aligned", 32'(aligned), 32'd0);
        chk("realign_comma",   32'(comma),   32'd1);

        // enable low outranks realign; long enough that a search window would expire
        for (int k = 0; k < 100; k++) begin
            cycle((k % 5 == 0) ? K28_5_RDN : 10'($urandom), 1'b0, 1'b1);
        end
        chk("disable_slip_bits",  32'(slip_bits),  32'd3);
        chk("disable_aligned",    32'(aligned),    32'd0);
        chk("disable_slip_count", 32'(slip_count), 32'd3);

        // commas visible only at slip 0: hunt from 3 through 9 and wrap to 0
        build_stream(1'b1);
        target    = 0;
        wrap_seen = 1'b0;
        prev_slip = int'(slip_bits);
        for (int k = 0; k < 1200 && aligned !== 1'b1; k++) begin
            gb_cycle(1'b1, 1'b0);
            if (prev_slip == 9 && slip_bits == 4'd0) wrap_seen = 1'b1;
            prev_slip = int'(slip_bits);
        end
        chk("wrap_seen",       32'(wrap_seen),  32'd1);
        chk("wrap_aligned",    32'(aligned),    32'd1);
        chk("wrap_slip_bits",  32'(slip_bits),  32'd0);
        chk("wrap_slip_count", 32'(slip_count), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/word_aligner_10b.md
Name: word_aligner_10b

Overview:
- Sits directly downstream of the receiver's 4-to-10 gearbox, in the gearbox output clock domain.
- Monitors one 10-bit lane for K28.5 commas and steps the gearbox slip_bits control (0..9) until commas land word-aligned.
- Confirms alignment with repeated comma hits, then asserts aligned and watches for loss of alignment.
- Passes the data through registered, with a comma flag, to the 8b/10b decoder.

Parameters:
- SEARCH_WINDOW, 64: cycles without a comma before advancing slip (HUNT/VERIFY).
- SETTLE_CYCLES, 8: cycles ignored after a slip change (gearbox applies slip only at its sequence wrap, plus pipeline).
- LOCK_COUNT, 4: consecutive-window comma hits required to declare alignment.
- LOSS_WINDOW, 256: cycles without a comma in LOCKED before alignment is dropped.

Ports:
- clock, input, 1: gearbox output (word) clock.
- reset_n, input, 1: asynchronous, active-low reset.
- datain, input, 10: gearbox lane word; bit 0 is the first-received bit.
- enable, input, 1: 0 holds the FSM in HUNT with all counters cleared; slip_bits is held.
- realign, input, 1: single-cycle request to drop lock and re-hunt.
- slip_bits, output, 4: slip select to the gearbox, range 0..9.
- dataout, output, 10: datain delayed one cycle.
- comma, output, 1: dataout is K28.5 (either disparity).
- aligned, output, 1: FSM is in LOCKED.
- slip_count, output, 8: number of slip advances since reset; saturates at 255.

Behaviour:
- Reset (async, reset_n=0): state=HUNT, slip_bits=0, dataout=0, comma=0, aligned=0, slip_count=0, all counters 0.
- Comma detect: datain==10'h17C (RD-) or 10'h283 (RD+). dataout and comma are both registered, so latency is 1 cycle. The detect is valid in every state.
- Window counter: cnt_win. It clears on every comma hit and on each state entry. It increments otherwise and saturates at its terminal value.
- HUNT:
  - Comma -> VERIFY with hits=1.
  - cnt_win==SEARCH_WINDOW-1 with no comma -> advance slip, then SETTLE.
- Slip advance: slip_bits <= (slip_bits==9) ? 0 : slip_bits+1; slip_count += 1, saturating. Values 10..15 are never driven.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then -> HUNT.
  - Commas are ignored; slip_bits is stable.
- VERIFY:
  - Each comma increments hits; when hits reaches LOCK_COUNT -> LOCKED.
  - SEARCH_WINDOW cycles without a comma -> advance slip, then SETTLE (hits=0).
- LOCKED:
  - aligned=1 and slip_bits is frozen.
  - A comma clears cnt_win.
  - cnt_win==LOSS_WINDOW-1 with no comma -> HUNT, aligned=0, slip unchanged (re-hunt starts at the current slip).
- aligned is registered and equals (state==LOCKED), so it rises the cycle after the LOCK_COUNT-th hit.
- realign=1 in any state -> HUNT next cycle, counters cleared, slip unchanged. realign has priority over a simultaneous comma or window expiry.
- enable=0 has priority over realign. dataout and comma keep updating while enable=0.
- A comma on the same cycle the window expires counts as a hit; no slip occurs.
- Counter widths are $clog2 of the respective parameter plus 1. No wrap-around is permitted except on slip_bits.

Decomposition:
- Shared package (lvds_rx_pkg) holds:
  - K28_5_RDN=10'h17C and K28_5_RDP=10'h283.
  - SLIP_MAX=9.
  - An enumerated state type {HUNT, SETTLE, VERIFY, LOCKED}.
- Sub-module comma_detect_10b: combinational match of the two comma values.
- The FSM, counters and output registers stay in word_aligner_10b.

Test Plan:
- Reset: reset_n=0 then 1 while datain=0 -> slip_bits=0, aligned=0, comma=0.
- No commas for 3*(SEARCH_WINDOW+SETTLE_CYCLES) cycles -> slip_bits 0->1->2->3 and slip_count=3.
- Drive a comma stream that is aligned only at slip 3 (bench model: gearbox plus serial source) -> lock at slip_bits=3, aligned=1 the cycle after the 4th hit.
- Slip wrap: aligned only at slip 0, starting from slip 9 -> 9->0 transition, then lock at 0.
- LOCKED with commas stopped for 256 cycles -> aligned=0 at cycle 256; re-hunt starts at the same slip_bits.
- Simultaneous events:
  - realign and comma in the same cycle while LOCKED -> HUNT, aligned=0 next cycle.
  - enable=0 with realign=1 -> FSM held in HUNT, slip_bits unchanged.
